sm_vram_arbiter: RTL and testbench

SM_VRAM_ARBITER -- requirements
Module: sm_vram_arbiter

---
 rtl/sm_vram_pkg.sv | 19 +
 rtl/sm_vram_arbiter.sv | 113 +++++++++++
 tb/tb_sm_vram_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/sm_vram_pkg.sv
// Shared encodings for the VRAM arbiter: FSM states, read-data owner tags, default widths.
package sm_vram_pkg;

  localparam int unsigned VramAddrW    = 15;
  localparam int unsigned VramDataW    = 12;
  localparam int unsigned StarveMaxDef = 8;

  typedef enum logic {
    StIdle    = 1'b0,
    StCpuDone = 1'b1
  } vram_state_e;

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnVid  = 2'd1,
    OwnCpu  = 2'd2
  } owner_e;

endpackage

// File: rtl/sm_vram_arbiter.sv
// Single-port VRAM arbiter: video scanout has strict priority, CPU gets idle slots.
// Tracks CPU wait time and raises a sticky starvation flag.
module sm_vram_arbiter
  import sm_vram_pkg::*;
#(
  parameter int unsigned ADDR_W     = VramAddrW,
  parameter int unsigned DATA_W     = VramDataW,
  parameter int unsigned STARVE_MAX = StarveMaxDef
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              cpu_starve
);

  localparam int unsigned    CntW   = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

  vram_state_e       state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              cpu_we_q, cpu_we_d;
  logic [CntW-1:0]   wait_q, wait_d;
  logic              starve_q, starve_d;
  logic [DATA_W-1:0] vid_hold_q;
  logic [DATA_W-1:0] cpu_hold_q;
  logic              cpu_grant;
  logic              cpu_rd_done;

  // Grant and VRAM command; gating with rst_n keeps the RAM write-protected during reset.
  always_comb begin
    cpu_grant = rst_n & ~vid_req & cpu_req & (state_q == StIdle);
    ram_addr  = vid_addr;
    if (cpu_grant) begin
      ram_addr = cpu_addr;
    end
    ram_we    = cpu_grant & cpu_we;
    ram_wdata = cpu_wdata;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (cpu_grant) state_d = StCpuDone;
      StCpuDone: state_d = StIdle;
    endcase
  end

  always_comb begin
    owner_d  = OwnNone;
    cpu_we_d = cpu_we_q;
    if (vid_req) begin
      owner_d = OwnVid;
    end else if (cpu_grant) begin
      owner_d  = OwnCpu;
      cpu_we_d = cpu_we;
    end
  end

  // Wait counter clears on grant or when the CPU withdraws its request.
  always_comb begin
    wait_d = wait_q;
    if (cpu_grant || !cpu_req) begin
      wait_d = '0;
    end else if (wait_q != CntMax) begin
      wait_d = wait_q + 1'b1;
    end
    starve_d = starve_q | (wait_d == CntMax);
  end

  // Read data is steered by the owner tag registered alongside the grant.
  always_comb begin
    vid_valid   = (owner_q == OwnVid);
    cpu_ack     = (state_q == StCpuDone);
    cpu_rd_done = (owner_q == OwnCpu) & ~cpu_we_q;
    vid_rdata   = vid_valid ? ram_rdata : vid_hold_q;
    cpu_rdata   = cpu_rd_done ? ram_rdata : cpu_hold_q;
    cpu_starve  = starve_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      owner_q    <= OwnNone;
      cpu_we_q   <= 1'b0;
      wait_q     <= '0;
      starve_q   <= 1'b0;
      vid_hold_q <= '0;
      cpu_hold_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cpu_we_q   <= cpu_we_d;
      wait_q     <= wait_d;
      starve_q   <= starve_d;
      vid_hold_q <= vid_rdata;
      cpu_hold_q <= cpu_rdata;
    end
  end

endmodule

// File: tb/tb_sm_vram_arbiter.sv
// Self-checking bench for sm_vram_arbiter: directed scenarios then random traffic,
// compared each cycle against a transaction-level model with its own shadow memory.
module tb_sm_vram_arbiter;

  localparam int unsigned AW   = 15;
  localparam int unsigned DW   = 12;
  localparam int unsigned SMAX = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_valid;
  logic [DW-1:0] vid_rdata;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          cpu_starve;

  always #5 clk = ~clk;

  sm_vram_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vid_req   (vid_req),
    .vid_addr  (vid_addr),
    .vid_valid (vid_valid),
    .vid_rdata (vid_rdata),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .cpu_starve(cpu_starve)
  );

  // External VRAM model and the reference model's independent shadow copy.
  logic [DW-1:0] vram   [2**AW];
  logic [DW-1:0] shadow [2**AW];

  int      n_checks = 0;
  int      n_fail   = 0;
  bit      armed    = 1'b0;
  bit      m_busy   = 1'b0;
  int      m_cnt    = 0;
  bit      m_starve = 1'b0;
  bit      m_vvalid = 1'b0;
  bit      m_ack    = 1'b0;
  logic [DW-1:0] m_vdata = '0;
  logic [DW-1:0] m_cdata = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check against model, then advance RAM and model at the edge.
  task automatic step(input bit r, input bit vr, input logic [AW-1:0] va, input bit cr,
                      input bit cw, input logic [AW-1:0] ca, input logic [DW-1:0] wd);
    bit            cg;
    bit            we_exp;
    logic [AW-1:0] s_addr;
    logic          s_we;
    logic [DW-1:0] s_wd;
    @(negedge clk);
    rst_n     = r;
    vid_req   = vr;
    vid_addr  = va;
    cpu_req   = cr;
    cpu_we    = cw;
    cpu_addr  = ca;
    cpu_wdata = wd;
    #1;
    cg     = r && !vr && cr && !m_busy;
    we_exp = cg && cw;
    check("ram_we", {31'd0, ram_we}, {31'd0, we_exp});
    if (r) check("ram_addr", {17'd0, ram_addr}, {17'd0, (cg ? ca : va)});
    if (we_exp) check("ram_wdata", {20'd0, ram_wdata}, {20'd0, wd});
    if (armed) begin
      check("vid_valid", {31'd0, vid_valid}, {31'd0, m_vvalid});
      check("vid_rdata", {20'd0, vid_rdata}, {20'd0, m_vdata});
      check("cpu_ack", {31'd0, cpu_ack}, {31'd0, m_ack});
      check("cpu_rdata", {20'd0, cpu_rdata}, {20'd0, m_cdata});
      check("cpu_starve", {31'd0, cpu_starve}, {31'd0, m_starve});
    end
    s_addr = ram_addr;
    s_we   = ram_we;
    s_wd   = ram_wdata;
    @(posedge clk);
    ram_rdata <= vram[s_addr];
    if (s_we) vram[s_addr] = s_wd;
    if (!r) begin
      armed    = 1'b1;
      m_busy   = 1'b0;
      m_cnt    = 0;
      m_starve = 1'b0;
      m_vvalid = 1'b0;
      m_ack    = 1'b0;
      m_vdata  = '0;
      m_cdata  = '0;
    end else begin
      m_vvalid = vr;
      if (vr) m_vdata = shadow[va];
      m_ack = cg;
      if (cg && !cw) m_cdata = shadow[ca];
      if (cg && cw) shadow[ca] = wd;
      m_busy = cg;
      if (cg || !cr) m_cnt = 0;
      else if (m_cnt < SMAX) m_cnt++;
      if (m_cnt == SMAX) m_starve = 1'b1;
    end
  endtask

  initial begin
    bit            cr_h;
    bit            cw_h;
    logic [AW-1:0] ca_h;
    logic [DW-1:0] wd_h;
    bit            r;
    bit            vr;
    bit            ack_now;

    for (int i = 0; i < 2**AW; i++) begin
      vram[i]   = DW'(i * 37 + 5);
      shadow[i] = DW'(i * 37 + 5);
    end
    rst_n = 1'b0; vid_req = 1'b0; vid_addr = '0; cpu_req = 1'b0;
    cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; ram_rdata = '0;

    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 15'h0005, 0, 0, 0, 0);

    // Lone CPU write, held through its ack.
    step(1, 0, 0, 1, 1, 15'h0010, 12'hF0A);
    step(1, 0, 0, 1, 1, 15'h0010, 12'hF0A);
    step(1, 0, 0, 0, 0, 0, 0);
    check("vram_0010", {20'd0, vram[15'h0010]}, 32'h0000_0F0A);

    // Video and CPU read collide: video first, CPU next cycle.
    step(1, 1, 15'h0010, 1, 0, 15'h0020, 0);
    step(1, 0, 0, 1, 0, 15'h0020, 0);
    step(1, 0, 0, 1, 0, 15'h0020, 0);
    step(1, 0, 0, 0, 0, 0, 0);

    // Ten back-to-back video reads starve a waiting CPU.
    for (int i = 0; i < 10; i++) step(1, 1, AW'(i + 16), 1, 0, 15'h0030, 0);
    check("starve_after_10", {31'd0, cpu_starve}, 32'd1);
    step(1, 0, 0, 1, 0, 15'h0030, 0);
    step(1, 0, 0, 1, 0, 15'h0030, 0);
    step(1, 0, 0, 0, 0, 0, 0);

    // Continuously held CPU read: ack, then regrant no sooner than two cycles later.
    for (int i = 0; i < 6; i++) step(1, 0, 0, 1, 0, 15'h0010, 0);
    step(1, 0, 0, 0, 0, 0, 0);

    // Reset lands in the ack cycle.
    step(1, 0, 0, 1, 0, 15'h0040, 0);
    step(0, 0, 0, 1, 0, 15'h0040, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("starve_cleared", {31'd0, cpu_starve}, 32'd0);

    // Alternating video with continuous CPU reads.
    for (int i = 0; i < 20; i++) step(1, (i % 2) == 0, AW'(i), 1, 0, AW'(i + 8), 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("starve_alt", {31'd0, cpu_starve}, 32'd0);

    // Random traffic over a small address window so reads hit recent writes.
    cr_h = 1'b0; cw_h = 1'b0; ca_h = '0; wd_h = '0;
    for (int i = 0; i < 600; i++) begin
      r       = ($urandom_range(0, 99) != 0);
      vr      = (i < 300) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) != 0);
      ack_now = m_busy;
      if (!ack_now) begin
        if (cr_h && $urandom_range(0, 9) == 0) cr_h = 1'b0;
        else if (!cr_h && $urandom_range(0, 1) == 1) begin
          cr_h = 1'b1;
          cw_h = ($urandom_range(0, 1) == 1);
          ca_h = AW'($urandom_range(0, 63));
          wd_h = DW'($urandom);
        end
      end
      step(r, vr, AW'($urandom_range(0, 63)), cr_h, cw_h, ca_h, wd_h);
      if (ack_now || !r) cr_h = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
